// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, NOP encoding, instruction field slices and fetch-state enum
package cpu_pkg;
  localparam int PC_W = 16;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  typedef enum logic {RUN, HALTED} fetchState_t;
  function automatic logic [3:0] fieldOpc(input logic [15:0] i);
    return i[15:12];
  endfunction
  function automatic logic [3:0] fieldR1(input logic [15:0] i);
    return i[11:8];
  endfunction
  function automatic logic [3:0] fieldR2(input logic [15:0] i);
    return i[7:4];
  endfunction
  function automatic logic [3:0] fieldR3(input logic [15:0] i);
    return i[3:0];
  endfunction
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush (bubble) beats load, otherwise holds
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         flush,
  input  logic [W-1:0] instrIn,
  input  logic [W-1:0] pcPlus2In,
  output logic [W-1:0] instr,
  output logic [W-1:0] pcPlus2,
  output logic         valid
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      instr   <= W'(NOP_INSTR);
      pcPlus2 <= '0;
      valid   <= 1'b0;
    end else if (flush) begin
      instr   <= W'(NOP_INSTR);
      pcPlus2 <= '0;
      valid   <= 1'b0;
    end else if (load) begin
      instr   <= instrIn;
      pcPlus2 <= pcPlus2In;
      valid   <= 1'b1;
    end
endmodule

// File: rtl/if_stage.sv
// if_stage: PC, next-PC mux, RUN/HALTED FSM and IF/ID register of the 16-bit CPU.
// Optional IF_STALL_CNT_EN adds a saturating stall_cnt output.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          PC_W     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wrPC,
  input  logic            IFIDWrite,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            halt_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [PC_W-1:0] imem_rdata,
  output logic [PC_W-1:0] ifid_instr,
  output logic [PC_W-1:0] ifid_pc_plus2,
  output logic            ifid_valid,
  output logic [3:0]      regR1,
  output logic [3:0]      regR2,
`ifdef IF_STALL_CNT_EN
  output logic [15:0]     stall_cnt,
`endif
  output logic            fetch_halted
);
  fetchState_t state;
  logic [PC_W-1:0] pc, pcPlus2;
  logic running, flush, load;
  assign running      = state == RUN;
  assign pcPlus2      = pc + PC_W'(2);
  assign imem_addr    = pc;
  assign fetch_halted = state == HALTED;
  // a taken branch is older than the stalled pair, so it wins over both stall signals
  assign flush = running && (branch_taken || halt_req);
  assign load  = running && !branch_taken && !halt_req && IFIDWrite;
  assign regR1 = fieldR1(ifid_instr[15:0]);
  assign regR2 = fieldR2(ifid_instr[15:0]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc    <= PC_W'(RESET_PC);
      state <= RUN;
    end else if (running) begin
      if (branch_taken) pc <= branch_target;
      else if (halt_req) state <= HALTED;
      else if (wrPC) pc <= pcPlus2;
    end
`ifdef IF_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (running && !branch_taken && !wrPC && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
  if_id_reg #(.W(PC_W)) u_ifid (
    .clk(clk), .rst_n(rst_n), .load(load), .flush(flush),
    .instrIn(imem_rdata), .pcPlus2In(pcPlus2),
    .instr(ifid_instr), .pcPlus2(ifid_pc_plus2), .valid(ifid_valid)
  );
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of fetch, stalls, redirect, halt, wrap-around and async reset
module tb_if_stage;
  logic clk = 0, rst_n = 0;
  logic wrPC = 1, IFIDWrite = 1, branch_taken = 0, halt_req = 0;
  logic [15:0] branch_target = 0, imem_addr, imem_rdata, ifid_instr, ifid_pc_plus2;
  logic ifid_valid, fetch_halted;
  logic [3:0] regR1, regR2;
`ifdef IF_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int assertCnt = 0, failCnt = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return a == 16'h0000 ? 16'h1234 : a == 16'h0002 ? 16'h5678 : a == 16'h0040 ? 16'hBEEF : a ^ 16'hC3C3;
  endfunction
  assign imem_rdata = memWord(imem_addr);

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .wrPC(wrPC), .IFIDWrite(IFIDWrite),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt_req(halt_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .ifid_instr(ifid_instr),
    .ifid_pc_plus2(ifid_pc_plus2), .ifid_valid(ifid_valid), .regR1(regR1), .regR2(regR2),
`ifdef IF_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .fetch_halted(fetch_halted)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    assertCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkStall(input string tag, input logic [15:0] exp);
`ifdef IF_STALL_CNT_EN
    check(tag, stall_cnt, exp);
`endif
  endtask

  initial begin
    #1;
    check("rst_addr", imem_addr, 16'h0000);
    check("rst_valid", 16'(ifid_valid), 16'h0);
    check("rst_instr", ifid_instr, 16'h0000);
    check("rst_halted", 16'(fetch_halted), 16'h0);
    checkStall("rst_stall", 16'h0);
    #2 rst_n = 1;
    step();
    check("f1_instr", ifid_instr, 16'h1234);
    check("f1_pc2", ifid_pc_plus2, 16'h0002);
    check("f1_valid", 16'(ifid_valid), 16'h1);
    check("f1_r1", 16'(regR1), 16'h2);
    check("f1_r2", 16'(regR2), 16'h3);
    step();
    check("f2_instr", ifid_instr, 16'h5678);
    check("f2_addr", imem_addr, 16'h0004);
    wrPC = 0; IFIDWrite = 0;
    step();
    check("lu_addr", imem_addr, 16'h0004);
    check("lu_instr", ifid_instr, 16'h5678);
    check("lu_pc2", ifid_pc_plus2, 16'h0004);
    checkStall("lu_stall", 16'h1);
    wrPC = 1; IFIDWrite = 1;
    step();
    check("lu_next", ifid_instr, 16'hC3C7);
    check("lu_next_pc2", ifid_pc_plus2, 16'h0006);
    branch_taken = 1; branch_target = 16'h0040; wrPC = 0; IFIDWrite = 0;
    step();
    check("br_addr", imem_addr, 16'h0040);
    check("br_valid", 16'(ifid_valid), 16'h0);
    check("br_instr", ifid_instr, 16'h0000);
    check("br_r1", 16'(regR1), 16'h0);
    checkStall("br_stall", 16'h1);
    branch_taken = 0; wrPC = 1; IFIDWrite = 1;
    step();
    check("br_tgt_instr", ifid_instr, 16'hBEEF);
    check("br_tgt_pc2", ifid_pc_plus2, 16'h0042);
    check("br_tgt_valid", 16'(ifid_valid), 16'h1);
    IFIDWrite = 0;
    step();
    check("ind1_addr", imem_addr, 16'h0044);
    check("ind1_instr", ifid_instr, 16'hBEEF);
    wrPC = 0; IFIDWrite = 1;
    step();
    check("ind2_addr", imem_addr, 16'h0044);
    check("ind2_instr", ifid_instr, 16'hC387);
    check("ind2_pc2", ifid_pc_plus2, 16'h0046);
    checkStall("ind2_stall", 16'h2);
    wrPC = 1; branch_taken = 1; branch_target = 16'hFFFE;
    step();
    check("wrap_addr0", imem_addr, 16'hFFFE);
    branch_taken = 0;
    step();
    check("wrap_addr1", imem_addr, 16'h0000);
    check("wrap_instr", ifid_instr, 16'h3C3D);
    check("wrap_pc2", ifid_pc_plus2, 16'h0000);
    for (int i = 0; i < 4; i++) step();
    check("pre_halt_addr", imem_addr, 16'h0008);
    halt_req = 1;
    step();
    check("halt_flag", 16'(fetch_halted), 16'h1);
    check("halt_addr", imem_addr, 16'h0008);
    check("halt_valid", 16'(ifid_valid), 16'h0);
    halt_req = 0; branch_taken = 1; branch_target = 16'h0040; wrPC = 0;
    step();
    check("halted_br_addr", imem_addr, 16'h0008);
    check("halted_br_valid", 16'(ifid_valid), 16'h0);
    check("halted_br_flag", 16'(fetch_halted), 16'h1);
    checkStall("halted_stall", 16'h2);
    branch_taken = 0; wrPC = 1;
    #3 rst_n = 0;
    #1;
    check("hrst_flag", 16'(fetch_halted), 16'h0);
    check("hrst_addr", imem_addr, 16'h0000);
    #1 rst_n = 1;
    step();
    check("hrst_fetch", ifid_instr, 16'h1234);
    wrPC = 0; IFIDWrite = 0;
    step();
    check("ar_pre_instr", ifid_instr, 16'h1234);
    #3 rst_n = 0;
    #1;
    check("ar_instr", ifid_instr, 16'h0000);
    check("ar_valid", 16'(ifid_valid), 16'h0);
    check("ar_pc2", ifid_pc_plus2, 16'h0000);
    check("ar_addr", imem_addr, 16'h0000);
    checkStall("ar_stall", 16'h0);
    wrPC = 1; IFIDWrite = 1;
    #1 rst_n = 1;
    step();
    check("ar_refetch", ifid_instr, 16'h1234);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end
endmodule
